// File: rtl/box_layer_renderer.sv
// Multi-box sprite renderer: shadow/active box registers committed at vblank start,
// per-pixel hit test against every box, lowest index wins, 2-cycle registered output.
module box_slot #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               commit,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [COORD_W-1:0] wr_w,
  input  logic [COORD_W-1:0] wr_h,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_enable,
  input  logic [COORD_W-1:0] X_pix,
  input  logic [COORD_W-1:0] Y_pix,
  output logic               hit,
  output logic [COLOR_W-1:0] color
);
  localparam int BW = 4*COORD_W + COLOR_W + 1;

  logic [BW-1:0]      sh_q, sh_d, act_q;
  logic [COORD_W-1:0] ax, ay, aw, ah;
  logic               aen;
  logic [COORD_W:0]   x_end, y_end;

  assign sh_d = {wr_x, wr_y, wr_w, wr_h, wr_color, wr_enable};
  assign {ax, ay, aw, ah, color, aen} = act_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      act_q <= '0;
    end else begin
      if (wr_en)  sh_q  <= sh_d;
      if (commit) act_q <= sh_q;
    end
  end

  // One extra bit on the far edge so boxes past the screen edge clip instead of wrapping.
  assign x_end = {1'b0, ax} + {1'b0, aw};
  assign y_end = {1'b0, ay} + {1'b0, ah};
  assign hit   = aen & (X_pix >= ax) & ({1'b0, X_pix} < x_end)
                     & (Y_pix >= ay) & ({1'b0, Y_pix} < y_end);
endmodule

module box_layer_renderer #(
  parameter int                 N_BOXES  = 4,
  parameter int                 COORD_W  = 10,
  parameter int                 COLOR_W  = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  parameter int                 IDX_W    = (N_BOXES > 1) ? $clog2(N_BOXES) : 1
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] X_pix,
  input  logic [COORD_W-1:0] Y_pix,
  input  logic               H_visible,
  input  logic               V_visible,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [COORD_W-1:0] wr_w,
  input  logic [COORD_W-1:0] wr_h,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_enable,
  output logic [COLOR_W-1:0] pixel_color,
  output logic [N_BOXES-1:0] hit_mask,
  output logic               frame_commit
);
  logic                             vvis_q, commit_q, rdy_q, wr_fire;
  logic [N_BOXES-1:0]               hit_w, hit_q;
  logic [N_BOXES-1:0][COLOR_W-1:0]  box_color;
  logic [COLOR_W-1:0]               col_d, col_q, pix_d, pix_q;
  logic                             vis_q;

  assign wr_ready     = rdy_q & ~commit_q;
  assign wr_fire      = wr_valid & wr_ready;
  assign frame_commit = commit_q;
  assign pixel_color  = pix_q;

  for (genvar i = 0; i < N_BOXES; i++) begin : g_box
    box_slot #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) u_box (
      .clk      (pixel_clk),
      .reset    (reset),
      .wr_en    (wr_fire && (wr_idx == IDX_W'(i))),
      .commit   (commit_q),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .wr_w     (wr_w),
      .wr_h     (wr_h),
      .wr_color (wr_color),
      .wr_enable(wr_enable),
      .X_pix    (X_pix),
      .Y_pix    (Y_pix),
      .hit      (hit_w[i]),
      .color    (box_color[i])
    );
  end

  // Winner colour is latched with the hits so a commit between stages cannot mix frames.
  always_comb begin
    col_d = BG_COLOR;
    for (int i = N_BOXES-1; i >= 0; i--)
      if (hit_w[i]) col_d = box_color[i];
  end

  always_comb begin
    pix_d = col_q;
    if (!vis_q) pix_d = '0;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vvis_q   <= 1'b0;
      commit_q <= 1'b0;
      rdy_q    <= 1'b0;
      hit_q    <= '0;
      col_q    <= '0;
      vis_q    <= 1'b0;
      pix_q    <= '0;
      hit_mask <= '0;
    end else begin
      vvis_q   <= V_visible;
      commit_q <= vvis_q & ~V_visible;
      rdy_q    <= 1'b1;
      hit_q    <= hit_w;
      col_q    <= col_d;
      vis_q    <= H_visible & V_visible;
      pix_q    <= pix_d;
      hit_mask <= hit_q;
    end
  end
endmodule
